// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: operation codes,
// sequencer state encoding and a small decode helper.
package mem_pkg;

    typedef enum logic [1:0] {
        RWE_NONE      = 2'b00,
        RWE_WRITE_REG = 2'b01,
        RWE_READ_MEM  = 2'b10,
        RWE_WRITE_MEM = 2'b11
    } rwe_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_HOLD   = 2'b11
    } mem_state_e;

    // Both SRAM operations share the upper code bit.
    function automatic logic is_mem_op(input rwe_e rwe);
        return rwe[1];
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side signals of the memory-access stage.
// Handshake: a memi_* word transfers on a rising edge where memi_valid=1 and memo_stall=0; memo_valid marks a one-cycle retire.
interface mem_access_if #(
    parameter int DATA_W = 16
);
    import mem_pkg::*;

    logic              memi_valid;
    logic [DATA_W-1:0] memi_instr;
    logic [DATA_W-1:0] memi_pc;
    logic [DATA_W-1:0] memi_data;
    logic [DATA_W-1:0] memi_mem_addr;
    logic [3:0]        memi_wreg_addr;
    rwe_e              memi_rwe;

    logic              memo_stall;
    logic              memo_valid;
    logic [DATA_W-1:0] memo_instr;
    logic [DATA_W-1:0] memo_pc;
    logic [DATA_W-1:0] memo_result;
    logic [3:0]        memo_wreg_addr;
    logic              memo_reg_wrn;

    modport master (
        output memi_valid, memi_instr, memi_pc, memi_data, memi_mem_addr, memi_wreg_addr, memi_rwe,
        input  memo_stall, memo_valid, memo_instr, memo_pc, memo_result, memo_wreg_addr, memo_reg_wrn
    );

    modport slave (
        input  memi_valid, memi_instr, memi_pc, memi_data, memi_mem_addr, memi_wreg_addr, memi_rwe,
        output memo_stall, memo_valid, memo_instr, memo_pc, memo_result, memo_wreg_addr, memo_reg_wrn
    );

endinterface

// File: rtl/mem_sram_seq.sv
// SRAM sequencer: setup / strobe / hold phases with a programmable strobe
// width, address and write-data latches, bus tristate and read capture.
module mem_sram_seq
    import mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output mem_state_e        state_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ram_en_o,
    output logic              ram_oe_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    inout  wire  [DATA_W-1:0] ram_data_io,
    output logic              drv_o
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              en_q, oe_q, we_q, drv_q;

    // Strobes and bus enable are registers with async clear, so reset
    // releases the SRAM immediately and abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            en_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drv_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_SETUP;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        wr_q    <= wr_i;
                        en_q    <= 1'b0;
                        drv_q   <= wr_i;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                    oe_q    <= wr_q;
                    we_q    <= !wr_q;
                end
                ST_STROBE: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) begin
                            rdata_q <= ram_data_io;
                        end
                        oe_q    <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    en_q    <= 1'b1;
                    drv_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_data_io = drv_q ? wdata_q : 'z;

    assign state_o    = state_q;
    assign rdata_o    = rdata_q;
    assign ram_en_o   = en_q;
    assign ram_oe_o   = oe_q;
    assign ram_we_o   = we_q;
    assign ram_addr_o = addr_q;
    assign drv_o      = drv_q;

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one-cycle registered pass-through for
// non-memory results, multi-cycle SRAM access with upstream stall otherwise.
module mem_access
    import mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_if.slave       mif,
    output logic              memo_ram_en,
    output logic              memo_ram_oe,
    output logic              memo_ram_we,
    output logic [ADDR_W-1:0] memo_ram_addr,
    inout  wire  [DATA_W-1:0] memio_ram_data,
    output mem_state_e        dbg_state_o,
    output logic              dbg_bus_drv_o
);

    mem_state_e        state;
    logic [DATA_W-1:0] rdata;
    logic              is_idle, seq_start;

    assign is_idle   = (state == ST_IDLE);
    assign seq_start = is_idle && mif.memi_valid && is_mem_op(mif.memi_rwe);

    // HOLD drops the stall so upstream advances on the same edge that retires.
    assign mif.memo_stall = seq_start || (state == ST_SETUP) || (state == ST_STROBE);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d, pc_q, pc_d, result_q, result_d;
    logic [3:0]        wreg_q, wreg_d;
    logic              reg_wrn_q, reg_wrn_d;
    logic [DATA_W-1:0] p_instr_q, p_instr_d, p_pc_q, p_pc_d;
    logic [3:0]        p_wreg_q, p_wreg_d;
    logic              p_rd_q, p_rd_d;

    always_comb begin
        valid_d   = 1'b0;
        instr_d   = instr_q;
        pc_d      = pc_q;
        result_d  = result_q;
        wreg_d    = wreg_q;
        reg_wrn_d = reg_wrn_q;
        p_instr_d = p_instr_q;
        p_pc_d    = p_pc_q;
        p_wreg_d  = p_wreg_q;
        p_rd_d    = p_rd_q;
        if (seq_start) begin
            p_instr_d = mif.memi_instr;
            p_pc_d    = mif.memi_pc;
            p_wreg_d  = mif.memi_wreg_addr;
            p_rd_d    = (mif.memi_rwe == RWE_READ_MEM);
        end else if (is_idle && mif.memi_valid) begin
            valid_d   = 1'b1;
            instr_d   = mif.memi_instr;
            pc_d      = mif.memi_pc;
            result_d  = mif.memi_data;
            wreg_d    = mif.memi_wreg_addr;
            reg_wrn_d = (mif.memi_rwe == RWE_WRITE_REG);
        end else if (state == ST_HOLD) begin
            valid_d   = 1'b1;
            instr_d   = p_instr_q;
            pc_d      = p_pc_q;
            result_d  = p_rd_q ? rdata : '0;
            wreg_d    = p_wreg_q;
            reg_wrn_d = p_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            result_q  <= '0;
            wreg_q    <= '0;
            reg_wrn_q <= 1'b0;
            p_instr_q <= '0;
            p_pc_q    <= '0;
            p_wreg_q  <= '0;
            p_rd_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            result_q  <= result_d;
            wreg_q    <= wreg_d;
            reg_wrn_q <= reg_wrn_d;
            p_instr_q <= p_instr_d;
            p_pc_q    <= p_pc_d;
            p_wreg_q  <= p_wreg_d;
            p_rd_q    <= p_rd_d;
        end
    end

    assign mif.memo_valid     = valid_q;
    assign mif.memo_instr     = instr_q;
    assign mif.memo_pc        = pc_q;
    assign mif.memo_result    = result_q;
    assign mif.memo_wreg_addr = wreg_q;
    assign mif.memo_reg_wrn   = reg_wrn_q;
    assign dbg_state_o        = state;

    mem_sram_seq #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .start_i     (seq_start),
        .wr_i        (mif.memi_rwe == RWE_WRITE_MEM),
        .addr_i      (ADDR_W'(mif.memi_mem_addr)),
        .wdata_i     (mif.memi_data),
        .state_o     (state),
        .rdata_o     (rdata),
        .ram_en_o    (memo_ram_en),
        .ram_oe_o    (memo_ram_oe),
        .ram_we_o    (memo_ram_we),
        .ram_addr_o  (memo_ram_addr),
        .ram_data_io (memio_ram_data),
        .drv_o       (dbg_bus_drv_o)
    );

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: two instances (strobe width 1 and 3), each with its
// own SRAM model, checked against a latency/result model of the stage.
module tb_mem_access;
    import mem_pkg::*;

    localparam int DW   = 16;
    localparam int AW   = 18;
    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic          rst_n     [NDUT];
    logic          in_valid  [NDUT];
    logic [DW-1:0] in_instr  [NDUT];
    logic [DW-1:0] in_pc     [NDUT];
    logic [DW-1:0] in_data   [NDUT];
    logic [DW-1:0] in_addr   [NDUT];
    logic [3:0]    in_wreg   [NDUT];
    rwe_e          in_rwe    [NDUT];

    logic          o_stall   [NDUT];
    logic          o_valid   [NDUT];
    logic [DW-1:0] o_instr   [NDUT];
    logic [DW-1:0] o_pc      [NDUT];
    logic [DW-1:0] o_result  [NDUT];
    logic [3:0]    o_wreg    [NDUT];
    logic          o_reg_wrn [NDUT];
    logic          ram_en    [NDUT];
    logic          ram_oe    [NDUT];
    logic          ram_we    [NDUT];
    logic [AW-1:0] ram_addr  [NDUT];
    logic [DW-1:0] bus_val   [NDUT];
    mem_state_e    dbg_state [NDUT];
    logic          dbg_drv   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : 3;
        mem_access_if #(.DATA_W(DW)) u_if ();
        wire  [DW-1:0] bus;
        logic [DW-1:0] sram [65536];

        assign u_if.memi_valid     = in_valid[g];
        assign u_if.memi_instr     = in_instr[g];
        assign u_if.memi_pc        = in_pc[g];
        assign u_if.memi_data      = in_data[g];
        assign u_if.memi_mem_addr  = in_addr[g];
        assign u_if.memi_wreg_addr = in_wreg[g];
        assign u_if.memi_rwe       = in_rwe[g];
        assign o_stall[g]   = u_if.memo_stall;
        assign o_valid[g]   = u_if.memo_valid;
        assign o_instr[g]   = u_if.memo_instr;
        assign o_pc[g]      = u_if.memo_pc;
        assign o_result[g]  = u_if.memo_result;
        assign o_wreg[g]    = u_if.memo_wreg_addr;
        assign o_reg_wrn[g] = u_if.memo_reg_wrn;
        assign bus_val[g]   = bus;

        mem_access #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) u_dut (
            .clk            (clk),
            .rst            (rst_n[g]),
            .mif            (u_if.slave),
            .memo_ram_en    (ram_en[g]),
            .memo_ram_oe    (ram_oe[g]),
            .memo_ram_we    (ram_we[g]),
            .memo_ram_addr  (ram_addr[g]),
            .memio_ram_data (bus),
            .dbg_state_o    (dbg_state[g]),
            .dbg_bus_drv_o  (dbg_drv[g])
        );

        // Asynchronous-read SRAM: drives while en and oe are low, writes on an edge with we low.
        initial for (int i = 0; i < 65536; i++) sram[i] = 16'(i) ^ 16'h5A5A;
        assign bus = (!ram_en[g] && !ram_oe[g]) ? sram[ram_addr[g][15:0]] : 'z;
        always @(posedge clk) if (!ram_en[g] && !ram_we[g]) sram[ram_addr[g][15:0]] <= bus;
    end

    // Reference memory contents: writes recorded at issue, untouched words keep their fill pattern.
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] last_res [NDUT];

    function automatic int wait_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] ref_read(input int s, input logic [DW-1:0] a);
        int key = s * 65536 + int'(a);
        if (ref_mem.exists(key)) return ref_mem[key];
        return a ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one instruction at the current negedge and follows it to retire.
    task automatic run_op(input int s, input rwe_e rwe, input logic [DW-1:0] data,
                          input logic [DW-1:0] addr, input logic [3:0] wreg, input bit perturb);
        int            w      = wait_of(s);
        bit            is_mem = (rwe == RWE_READ_MEM) || (rwe == RWE_WRITE_MEM);
        bit            is_wr  = (rwe == RWE_WRITE_MEM);
        bit            is_rd  = (rwe == RWE_READ_MEM);
        int            lat    = is_mem ? w + 3 : 1;
        int            stall_n = 0, oe_n = 0, we_n = 0, en_n = 0, drv_n = 0;
        logic [DW-1:0] instr  = 16'($urandom);
        logic [DW-1:0] pc     = 16'($urandom);
        logic [DW-1:0] exp_res;
        logic          exp_wrn;
        case (rwe)
            RWE_NONE:      begin exp_res = data; exp_wrn = 1'b0; end
            RWE_WRITE_REG: begin exp_res = data; exp_wrn = 1'b1; end
            RWE_READ_MEM:  begin exp_res = ref_read(s, addr); exp_wrn = 1'b1; end
            default:       begin exp_res = '0; exp_wrn = 1'b0; ref_mem[s * 65536 + int'(addr)] = data; end
        endcase
        in_valid[s] = 1'b1; in_rwe[s] = rwe; in_data[s] = data; in_addr[s] = addr;
        in_wreg[s] = wreg; in_instr[s] = instr; in_pc[s] = pc;
        for (int c = 0; c < lat; c++) begin
            #1;
            if (o_stall[s]) stall_n++;
            if (!ram_oe[s]) oe_n++;
            if (!ram_we[s]) we_n++;
            if (dbg_drv[s]) begin
                drv_n++;
                check("bus_wdata", 32'(bus_val[s]), 32'(data));
            end
            if (!ram_en[s]) begin
                en_n++;
                check("ram_addr", 32'(ram_addr[s]), {16'h0, addr});
            end
            next_cycle();
            if (c < lat - 1) check("valid_in_flight", 32'(o_valid[s]), 32'h0);
            if (perturb && c == 1) begin
                in_addr[s] = 16'($urandom); in_data[s] = 16'($urandom);
                in_instr[s] = 16'($urandom); in_wreg[s] = 4'($urandom);
            end
        end
        check("stall_cycles", 32'(stall_n), is_mem ? 32'(w + 2) : 32'h0);
        check("oe_low_cycles", 32'(oe_n), is_rd ? 32'(w) : 32'h0);
        check("we_low_cycles", 32'(we_n), is_wr ? 32'(w) : 32'h0);
        check("en_low_cycles", 32'(en_n), is_mem ? 32'(w + 2) : 32'h0);
        check("bus_drive_cycles", 32'(drv_n), is_wr ? 32'(w + 2) : 32'h0);
        check("retire_valid", 32'(o_valid[s]), 32'h1);
        check("retire_result", 32'(o_result[s]), 32'(exp_res));
        check("retire_reg_wrn", 32'(o_reg_wrn[s]), 32'(exp_wrn));
        check("retire_wreg", 32'(o_wreg[s]), 32'(wreg));
        check("retire_instr", 32'(o_instr[s]), 32'(instr));
        check("retire_pc", 32'(o_pc[s]), 32'(pc));
        last_res[s] = exp_res;
    endtask

    task automatic idle(input int s, input int n);
        in_valid[s] = 1'b0;
        in_data[s]  = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            check("idle_valid", 32'(o_valid[s]), 32'h0);
            check("idle_result_hold", 32'(o_result[s]), 32'(last_res[s]));
        end
    endtask

    task automatic check_reset_state(input int s);
        check("rst_valid", 32'(o_valid[s]), 32'h0);
        check("rst_stall", 32'(o_stall[s]), 32'h0);
        check("rst_instr", 32'(o_instr[s]), 32'h0);
        check("rst_pc", 32'(o_pc[s]), 32'h0);
        check("rst_result", 32'(o_result[s]), 32'h0);
        check("rst_wreg", 32'(o_wreg[s]), 32'h0);
        check("rst_reg_wrn", 32'(o_reg_wrn[s]), 32'h0);
        check("rst_ram_en", 32'(ram_en[s]), 32'h1);
        check("rst_ram_oe", 32'(ram_oe[s]), 32'h1);
        check("rst_ram_we", 32'(ram_we[s]), 32'h1);
        check("rst_ram_addr", 32'(ram_addr[s]), 32'h0);
        check("rst_bus_drive", 32'(dbg_drv[s]), 32'h0);
        check("rst_state", 32'(dbg_state[s]), 32'(ST_IDLE));
    endtask

    // Reset applied in the first strobe cycle of a write abandons it with no retire.
    task automatic reset_mid_write(input int s);
        in_valid[s] = 1'b1; in_rwe[s] = RWE_WRITE_MEM; in_data[s] = 16'hDEAD;
        in_addr[s] = 16'h0777; in_wreg[s] = 4'h2;
        next_cycle();
        next_cycle();
        check("pre_rst_we_low", 32'(ram_we[s]), 32'h0);
        check("pre_rst_bus_drive", 32'(dbg_drv[s]), 32'h1);
        rst_n[s] = 1'b0;
        in_valid[s] = 1'b0;
        #1;
        check("async_rst_en", 32'(ram_en[s]), 32'h1);
        check("async_rst_oe", 32'(ram_oe[s]), 32'h1);
        check("async_rst_we", 32'(ram_we[s]), 32'h1);
        check("async_rst_bus_drive", 32'(dbg_drv[s]), 32'h0);
        check("async_rst_state", 32'(dbg_state[s]), 32'(ST_IDLE));
        next_cycle();
        rst_n[s] = 1'b1;
        last_res[s] = '0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("post_rst_valid", 32'(o_valid[s]), 32'h0);
            check("post_rst_en", 32'(ram_en[s]), 32'h1);
        end
    endtask

    initial begin
        for (int s = 0; s < NDUT; s++) begin
            rst_n[s] = 1'b0; in_valid[s] = 1'b0; in_rwe[s] = RWE_NONE; in_data[s] = '0;
            in_addr[s] = '0; in_wreg[s] = '0; in_instr[s] = '0; in_pc[s] = '0; last_res[s] = '0;
        end
        repeat (3) next_cycle();
        for (int s = 0; s < NDUT; s++) check_reset_state(s);
        for (int s = 0; s < NDUT; s++) rst_n[s] = 1'b1;
        next_cycle();

        for (int s = 0; s < NDUT; s++) begin
            run_op(s, RWE_WRITE_REG, 16'h1234, 16'h0000, 4'd5, 1'b0);
            run_op(s, RWE_NONE, 16'h00A5, 16'h0010, 4'd3, 1'b0);
            run_op(s, RWE_WRITE_REG, 16'hFFFF, 16'h0000, 4'd15, 1'b0);
            idle(s, 1);
            run_op(s, RWE_WRITE_MEM, 16'hBEEF, 16'h0040, 4'd1, 1'b0);
            run_op(s, RWE_READ_MEM, 16'h0000, 16'h0040, 4'd7, 1'b0);
            idle(s, 2);
            run_op(s, RWE_READ_MEM, 16'h0000, 16'h0041, 4'd2, 1'b0);
            run_op(s, RWE_READ_MEM, 16'h0000, 16'hFFFF, 4'd3, 1'b0);
            run_op(s, RWE_READ_MEM, 16'h0000, 16'h0040, 4'd4, 1'b0);
            run_op(s, RWE_WRITE_REG, 16'h5555, 16'h0000, 4'd9, 1'b0);
            run_op(s, RWE_READ_MEM, 16'h0000, 16'h0040, 4'd6, 1'b1);
            run_op(s, RWE_WRITE_MEM, 16'h1357, 16'h0050, 4'd6, 1'b1);
            run_op(s, RWE_READ_MEM, 16'h0000, 16'h0050, 4'd8, 1'b0);
            for (int i = 0; i < 40; i++) begin
                rwe_e          r = rwe_e'($urandom_range(0, 3));
                logic [DW-1:0] a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7) << 4);
                run_op(s, r, 16'($urandom), a, 4'($urandom), $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 5) == 0) idle(s, $urandom_range(1, 2));
            end
            idle(s, 1);
            reset_mid_write(s);
            run_op(s, RWE_READ_MEM, 16'h0000, 16'h0040, 4'd11, 1'b0);
            idle(s, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Parametrised memory-access pipeline stage for the 16-bit CPU, sitting between the EX/MEM pipeline register and write-back. It replaces single-cycle combinational SRAM access with a registered, multi-cycle SRAM sequencer that has setup/strobe/hold phases and a configurable wait count. It stalls the upstream pipeline while an access is in flight, and passes non-memory results through in one registered cycle.

## Interface
- DATA_W, 16, data, instruction and PC width
- ADDR_W, 18, SRAM address width; must be ≥ DATA_W
- WAIT_CYCLES, 1, strobe-low cycles per access; must be ≥ 1
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- memi_valid  in  1  upstream presents an instruction
- memi_instr  in  DATA_W  instruction word, passed through
- memi_pc  in  DATA_W  PC, passed through
- memi_data  in  DATA_W  ALU result (non-memory) or store data (write)
- memi_mem_addr  in  DATA_W  memory address for read and write
- memi_wreg_addr  in  4  destination register
- memi_rwe  in  2  operation code from the package: NONE, WRITE_REG, READ_MEM, WRITE_MEM
- memo_stall  out  1  upstream must hold all memi_* stable
- memo_valid  out  1  memo_* below carry a retired instruction this cycle
- memo_instr, memo_pc  out  DATA_W  registered copies
- memo_result  out  DATA_W  write-back value
- memo_wreg_addr  out  4  registered destination
- memo_reg_wrn  out  1  register write enable for write-back
- memo_ram_en, memo_ram_oe, memo_ram_we  out  1  SRAM controls, active-low
- memo_ram_addr  out  ADDR_W  SRAM address
- memio_ram_data  inout  DATA_W  SRAM data bus

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE, memi_valid with NONE or WRITE_REG:
  - Registered pass-through at the next edge.
  - memo_result = memi_data; memo_reg_wrn = (rwe==WRITE_REG).
  - memo_valid = 1 for one cycle. No stall.
- IDLE, memi_valid with READ_MEM or WRITE_MEM:
  - memo_stall = 1 combinationally.
  - At the edge: latch address (memi_mem_addr zero-extended to ADDR_W), store data and rwe; go to SETUP.
- SETUP:
  - ram_en = 0, address stable, oe = we = 1.
  - For a write, the bus is driven with the latched data.
  - Load wait counter = WAIT_CYCLES−1; go to STROBE.
- STROBE:
  - Read: oe = 0. Write: we = 0.
  - Counter decrements each cycle.
  - When the counter is 0: a read samples memio_ram_data into the result register at that edge; go to HOLD.
- HOLD:
  - oe = we = 1, en = 0, address held.
  - A write keeps driving the bus (hold time).
  - memo_stall = 0, so upstream advances at this edge.
  - At the edge: memo_* are registered and memo_valid = 1; go to IDLE.
- Read retire: memo_result = sampled data, memo_reg_wrn = 1.
- Write retire: memo_result = 0, memo_reg_wrn = 0.
- Bus direction:
  - Driven only in SETUP/STROBE/HOLD of a write; Z otherwise.
  - A read following a write therefore always sees at least one cycle of bus release (IDLE).
- memi_valid = 0 in IDLE: memo_valid = 0 next cycle; other memo_* hold their last value.

## Timing
- Reset values: state IDLE, memo_valid 0, memo_stall 0, memo_instr/pc/result/wreg_addr 0, memo_reg_wrn 0, ram_en/oe/we 1, ram_addr 0, bus Z.
- Reset asserted mid-access: strobes deassert and the bus releases asynchronously; the access is abandoned with no retire.
- Non-memory latency: 1 cycle; throughput 1 per cycle.
- Memory latency: WAIT_CYCLES+3 edges from the first IDLE cycle to memo_valid. Stall is high for WAIT_CYCLES+2 cycles.
- Back-to-back memory ops: the second enters IDLE the cycle after HOLD. Period is WAIT_CYCLES+3.
- Inputs are sampled only in IDLE. Changes to memi_* during SETUP/STROBE/HOLD are ignored.

## Structure
- Shared package mem_pkg: RWE_NONE=2'b00, RWE_WRITE_REG=2'b01, RWE_READ_MEM=2'b10, RWE_WRITE_MEM=2'b11; FSM state encoding.
- One sub-module, mem_sram_seq, containing:
  - the FSM and wait counter;
  - the address/data latches and the bus tristate;
  - the read capture.
- mem_access handles pass-through, output registers and stall logic.

## Test plan
- Reset: hold rst=0 mid-STROBE of a write → en/oe/we=1 and bus Z immediately; memo_valid=0 after release.
- Pass-through: WRITE_REG, data 0x1234, wreg 5 → next cycle memo_valid=1, result 0x1234, reg_wrn=1, stall never high.
- Write then read, WAIT_CYCLES=1: write 0xBEEF to 0x0040, then read 0x0040 from the SRAM model.
  - Write: we low exactly 1 cycle, bus driven SETUP..HOLD only.
  - Read: result 0xBEEF, reg_wrn=1, 4 edges after issue.
- WAIT_CYCLES=3: read → oe low exactly 3 cycles, stall high 5 cycles, memo_valid on the 6th edge.
- Back-to-back: 3 reads then 1 WRITE_REG → 3 memory retires spaced 4 cycles apart, then the WRITE_REG retires the cycle after.
- Input perturbation: change memi_mem_addr during STROBE → ram_addr unchanged, correct data returned.
